// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the all-zero control word used for bubbles, the hard-wired zero register
// index and the width of the memory-wait counter.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    // Packed control word injected into ID/EX when a bubble is requested.
    localparam logic [31:0] CTRL_ZERO = 32'b0;

    // Register r0 is hard-wired to zero and can never carry a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int WAIT_W = 8;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator. Flags a hazard when the
// instruction in EX is a load whose destination (non-zero) matches either
// source register of the instruction in ID.
//
// Ports:
//   idex_memread_i  instruction in EX is a load
//   idex_rt_i       destination register of the load in EX
//   ifid_rs_i       rs field of the instruction in ID
//   ifid_rt_i       rt field of the instruction in ID
//   hazard_o        1 = ID must stall one cycle behind the load
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       hazard_o
);

    assign hazard_o = idex_memread_i
                   && (idex_rt_i != REG_ZERO)
                   && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Stalls on load-use
// hazards, flushes IF/ID on taken branches, freezes the pipe while data
// memory is busy and falls into a sticky ERROR state if memory never answers.
// All control outputs are Mealy: a stall takes effect in the cycle the
// hazard is seen.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               leave IDLE and begin execution
//   IFID_rs_i/IFID_rt_i   source fields of the instruction in ID
//   IDEX_MemRead_i        instruction in EX is a load
//   IDEX_rt_i             destination of the instruction in EX
//   Branch_taken_i        branch in ID resolved taken
//   Dmem_req_i/ack_i      data-memory access / completion in MEM
//   PC_write_o            PC update enable
//   IFID_write_o          IF/ID write enable
//   IFID_flush_o          clear IF/ID to NOP
//   IDEX_bubble_o         force ID/EX control word to zero
//   EXMEM_hold_o          hold EX/MEM and ID/EX
//   MEMWB_bubble_o        zero control word into MEM/WB
//   state_o               registered FSM state
//   stall_count_o         saturating count of stalled cycles
//   error_o               sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IFID_rs_i,
    input  logic [4:0]       IFID_rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rt_i,
    input  logic             Branch_taken_i,
    input  logic             Dmem_req_i,
    input  logic             Dmem_ack_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_hold_o,
    output logic             MEMWB_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic             error_o
);

    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load_use;
    logic              mem_stall;

    load_use_detect u_load_use_detect (
        .idex_memread_i (IDEX_MemRead_i),
        .idex_rt_i      (IDEX_rt_i),
        .ifid_rs_i      (IFID_rs_i),
        .ifid_rt_i      (IFID_rt_i),
        .hazard_o       (load_use)
    );

    // An access that completes in the same cycle it is issued is not a stall.
    assign mem_stall = Dmem_req_i && !Dmem_ack_i;

    // Next-state and Mealy outputs.
    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no
        // path through the case leaves one unassigned (which would infer a latch).
        state_d        = state_q;
        wait_d         = wait_q;
        PC_write_o     = 1'b0;
        IFID_write_o   = 1'b0;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_hold_o   = 1'b0;
        MEMWB_bubble_o = 1'b0;
        error_o        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end

            ST_RUN: begin
                PC_write_o   = 1'b1;
                IFID_write_o = 1'b1;
                // Priority order: memory freeze, load-use, branch flush.
                // A branch under a stall is not flushed because ID will
                // re-resolve it once the stall clears.
                if (mem_stall) begin
                    PC_write_o     = 1'b0;
                    IFID_write_o   = 1'b0;
                    EXMEM_hold_o   = 1'b1;
                    MEMWB_bubble_o = 1'b1;
                    state_d        = ST_MEMWAIT;
                    wait_d         = WAIT_W'(1);
                end else if (load_use) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                end else if (Branch_taken_i) begin
                    IFID_flush_o = 1'b1;
                end
            end

            ST_MEMWAIT: begin
                EXMEM_hold_o   = 1'b1;
                MEMWB_bubble_o = 1'b1;
                // The ack cycle itself stays frozen; MEM/WB captures the
                // returned data on the next edge. Ack wins over timeout.
                if (Dmem_ack_i) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT_VAL) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_ERROR: begin
                EXMEM_hold_o   = 1'b1;
                MEMWB_bubble_o = 1'b1;
                error_o        = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Stalled cycles are counted only while the pipe is meant to be running.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_RUN || state_q == ST_MEMWAIT) && !PC_write_o
            && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign state_o       = state_q;
    assign stall_count_o = stall_q;

endmodule : pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards and flushes IF/ID on taken branches. It freezes the whole pipe while data memory is busy, with a timeout to a sticky error state. Its outputs gate the PC and IF/ID write enables, zero the packed 32-bit control word entering ID/EX (bubble), and hold EX/MEM.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEMWAIT cycles without ack before entering ERROR (1..255)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  leave IDLE and begin execution
IFID_rs_i  in  5  rs field of instruction in ID
IFID_rt_i  in  5  rt field of instruction in ID
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_rt_i  in  5  destination rt of instruction in EX
Branch_taken_i  in  1  branch in ID resolved taken
Dmem_req_i  in  1  MEM stage is accessing data memory this cycle
Dmem_ack_i  in  1  data memory completes access this cycle
PC_write_o  out  1  PC update enable
IFID_write_o  out  1  IF/ID register write enable
IFID_flush_o  out  1  clear IF/ID to NOP
IDEX_bubble_o  out  1  force packed control word into ID/EX to 32'b0
EXMEM_hold_o  out  1  EX/MEM and ID/EX hold current contents
MEMWB_bubble_o  out  1  MEM/WB receives zero control word
state_o  out  2  current state encoding
stall_count_o  out  CNT_W  saturating count of stalled cycles
error_o  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, wait counter 0, stall_count_o 0, error_o 0. Overrides everything, including mid-MEMWAIT and ERROR.
- Outputs are combinational from state and current inputs (Mealy), so a stall takes effect in the cycle the hazard is seen.
- IDLE: PC_write_o=0, IFID_write_o=0, all other controls 0. start_i=1 -> RUN next cycle.
- RUN, default: PC_write_o=1, IFID_write_o=1, others 0. start_i is ignored. Priority applies highest first:
  1. Mem freeze, when Dmem_req_i=1 and Dmem_ack_i=0:
     - PC_write_o=0, IFID_write_o=0, EXMEM_hold_o=1, MEMWB_bubble_o=1.
     - Next state MEMWAIT, wait counter cleared to 1.
     - Dmem_req_i=1 with Dmem_ack_i=1 in the same cycle is not a stall.
  2. Load-use, when IDEX_MemRead_i=1, IDEX_rt_i!=0, and IDEX_rt_i equals IFID_rs_i or IFID_rt_i:
     - PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1 for exactly this cycle.
     - State stays RUN.
  3. Branch, when Branch_taken_i=1: IFID_flush_o=1, all enables stay 1.
- Suppression under higher priority: a taken branch during a load-use or mem freeze does not flush, because ID re-evaluates the branch after the stall. IDEX_bubble_o is not asserted during a mem freeze.
- MEMWAIT: outputs are the same as a mem freeze.
  - Dmem_ack_i=1: this cycle is still frozen (MEM/WB captures the data next edge); next state RUN, counter cleared.
  - Otherwise the counter increments. If counter == MEM_TIMEOUT and no ack -> ERROR.
  - Ack arriving in the same cycle the counter reaches MEM_TIMEOUT counts as ack, so the block returns to RUN.
- ERROR: all enables 0, EXMEM_hold_o=1, MEMWB_bubble_o=1, error_o=1. Leaves only via reset.
- stall_count_o: +1 every cycle in RUN or MEMWAIT with PC_write_o=0. Saturates at 2^CNT_W-1 and does not wrap. Does not count in IDLE or ERROR.
- State encoding: IDLE=0, RUN=1, MEMWAIT=2, ERROR=3; state_o shows the registered state.

Decomposition:
- Shared package pipe_ctrl_pkg: state encodings, CTRL_ZERO (32'b0 control word), REG_ZERO (5'd0).
- One sub-module, load_use_detect: purely combinational comparator taking the IDEX_MemRead/rt and IFID rs/rt fields, with a 1-bit hazard output.
- FSM, wait counter and stall counter live in the top module.

Test Plan:
- Reset/start: rst_i for 2 cycles, then start_i pulse -> state_o 0 then 1; PC_write_o 0 in IDLE, 1 in RUN; stall_count_o=0.
- Load-use: IDEX_MemRead_i=1, IDEX_rt_i=8, IFID_rs_i=8 for one cycle -> PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1 that cycle only; stall_count_o=1. Repeat with IDEX_rt_i=0 -> no stall.
- Branch vs load-use: Branch_taken_i=1 with no hazard -> IFID_flush_o=1. Branch_taken_i=1 together with a load-use hazard -> IFID_flush_o=0 and IDEX_bubble_o=1.
- Memory wait: Dmem_req_i=1, ack after 4 cycles -> freeze for 5 cycles including the ack cycle, MEMWB_bubble_o=1 throughout, then RUN; stall_count_o +5.
- Timeout: MEM_TIMEOUT=3, Dmem_req_i held with no ack -> ERROR after the 3rd MEMWAIT cycle with error_o=1 sticky. A later ack leaves it in ERROR; rst_i returns to IDLE.
- Saturation/reset mid-op: CNT_W=4 with continuous load-use -> stall_count_o sticks at 15. Assert rst_i during MEMWAIT -> next cycle IDLE, counters 0.
